// File: rtl/noc_pe_sequencer.sv
// noc_pe_sequencer: gathers operands from the network and/or configured constants,
// drives a combinational 64-bit operator, and injects the result as a one-flit packet.
module noc_pe_sequencer #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEST_W    = 4,
    parameter int unsigned BUF_DEPTH = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [DEST_W-1:0]        cfg_dest,
    input  logic                     cfg_vc,
    input  logic [1:0]               cfg_src_mask,
    input  logic [DATA_W-1:0]        cfg_op_a,
    input  logic [DATA_W-1:0]        cfg_op_b,
    input  logic                     cfg_repeat,
    input  logic                     cfg_stop,
    input  logic [DATA_W+DEST_W+2:0] rx_flit,
    output logic [1:0]               rx_credit,
    output logic                     rx_credit_en,
    output logic [DATA_W-1:0]        op_a,
    output logic [DATA_W-1:0]        op_b,
    input  logic [DATA_W-1:0]        op_result,
    output logic [DATA_W+DEST_W+2:0] tx_flit,
    input  logic [1:0]               tx_credit,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned FLIT_W  = DATA_W + DEST_W + 3;
    localparam int unsigned VALID_B = FLIT_W - 1;
    localparam int unsigned VC_B    = DATA_W;
    localparam int unsigned NUM_VC  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EXEC    = 2'd2,
        ST_SEND    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic                vc_q, vc_d;
    logic [1:0]          mask_q, mask_d;
    logic                repeat_q, repeat_d;
    logic                stop_q, stop_d;
    logic                a_got_q, a_got_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]    credit_q [NUM_VC];
    logic [CNT_W-1:0]    credit_d [NUM_VC];
    logic [FLIT_W-1:0]   tx_flit_q, tx_flit_d;
    logic [1:0]          rx_credit_q, rx_credit_d;
    logic                rx_credit_en_q, rx_credit_en_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                rx_valid;
    logic [DATA_W-1:0]   rx_data;
    logic                sending;
    logic [NUM_VC-1:0]   cr_dec;
    logic [NUM_VC-1:0]   cr_inc;
    logic [DEST_W:0]     rx_hdr_unused;

    assign rx_valid      = rx_flit[VALID_B];
    assign rx_data       = rx_flit[DATA_W-1:0];
    assign rx_hdr_unused = rx_flit[FLIT_W-2:VC_B+1];
    // A registered valid tx flit means this cycle is the injection cycle
    assign sending       = tx_flit_q[VALID_B];

    // Next-state, operand capture, credit bookkeeping and registered-output lookahead
    always_comb begin
        state_d        = state_q;
        dest_d         = dest_q;
        vc_d           = vc_q;
        mask_d         = mask_q;
        repeat_d       = repeat_q;
        stop_d         = stop_q;
        a_got_d        = a_got_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        result_d       = result_q;
        credit_d       = credit_q;
        err_d          = err_q;
        tx_flit_d      = '0;
        cr_dec         = '0;
        cr_inc         = '0;
        rx_credit_en_d = rx_valid;
        rx_credit_d    = {rx_valid, rx_valid & rx_flit[VC_B]};
        done_d         = sending;

        // Every received flit is credited; only COLLECT may consume it
        if (rx_valid && (state_q != ST_COLLECT)) begin
            err_d = 1'b1;
        end

        if ((state_q != ST_IDLE) && cfg_stop) begin
            stop_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    dest_d   = cfg_dest;
                    vc_d     = cfg_vc;
                    mask_d   = cfg_src_mask;
                    repeat_d = cfg_repeat;
                    a_got_d  = 1'b0;
                    op_a_d   = cfg_src_mask[0] ? '0 : cfg_op_a;
                    op_b_d   = cfg_src_mask[1] ? '0 : cfg_op_b;
                    state_d  = (cfg_src_mask == 2'b00) ? ST_EXEC : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rx_valid) begin
                    if (mask_q[0] && !a_got_q) begin
                        op_a_d  = rx_data;
                        a_got_d = 1'b1;
                        if (!mask_q[1]) begin
                            state_d = ST_EXEC;
                        end
                    end else begin
                        op_b_d  = rx_data;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                result_d = op_result;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (sending) begin
                    if (repeat_q && !(stop_q || cfg_stop)) begin
                        a_got_d = 1'b0;
                        state_d = (mask_q == 2'b00) ? ST_EXEC : ST_COLLECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            stop_d = 1'b0;
        end

        // Send takes a credit, a return gives one back; both together cancel
        for (int v = 0; v < NUM_VC; v++) begin
            cr_dec[v] = sending && (vc_q == 1'(v));
            cr_inc[v] = tx_credit[1] && (tx_credit[0] == 1'(v));
            if (cr_inc[v] && !cr_dec[v]) begin
                if (credit_q[v] >= CNT_W'(BUF_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CNT_W'(1);
                end
            end else if (cr_dec[v] && !cr_inc[v]) begin
                credit_d[v] = credit_q[v] - CNT_W'(1);
            end
        end

        // Flit is registered, so launch it when next cycle is SEND with a credit
        if ((state_d == ST_SEND) && (credit_d[vc_q] != '0)) begin
            tx_flit_d = {1'b1, 1'b1, dest_q, vc_q, result_d};
        end

        cfg_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            dest_q         <= '0;
            vc_q           <= 1'b0;
            mask_q         <= '0;
            repeat_q       <= 1'b0;
            stop_q         <= 1'b0;
            a_got_q        <= 1'b0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            result_q       <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_q[v] <= CNT_W'(BUF_DEPTH);
            end
            tx_flit_q      <= '0;
            rx_credit_q    <= '0;
            rx_credit_en_q <= 1'b0;
            cfg_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            dest_q         <= dest_d;
            vc_q           <= vc_d;
            mask_q         <= mask_d;
            repeat_q       <= repeat_d;
            stop_q         <= stop_d;
            a_got_q        <= a_got_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            result_q       <= result_d;
            credit_q       <= credit_d;
            tx_flit_q      <= tx_flit_d;
            rx_credit_q    <= rx_credit_d;
            rx_credit_en_q <= rx_credit_en_d;
            cfg_ready_q    <= cfg_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign rx_credit    = rx_credit_q;
    assign rx_credit_en = rx_credit_en_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign tx_flit      = tx_flit_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_noc_pe_sequencer.sv
// tb_noc_pe_sequencer: directed scenarios checked against a transaction-level model every cycle
module tb_noc_pe_sequencer;

    localparam int BUF_DEPTH = 8;
    localparam int OP_ADD = 0;
    localparam int OP_MUL = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;

    logic        CLK;
    logic        RST;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_dest;
    logic        cfg_vc;
    logic [1:0]  cfg_src_mask;
    logic [63:0] cfg_op_a;
    logic [63:0] cfg_op_b;
    logic        cfg_repeat;
    logic        cfg_stop;
    logic [70:0] rx_flit;
    logic [1:0]  rx_credit;
    logic        rx_credit_en;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] op_result;
    logic [70:0] tx_flit;
    logic [1:0]  tx_credit;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int op_sel = OP_ADD;
    bit chk_en = 1'b0;

    noc_pe_sequencer dut (
        .CLK          (CLK),
        .RST          (RST),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_dest     (cfg_dest),
        .cfg_vc       (cfg_vc),
        .cfg_src_mask (cfg_src_mask),
        .cfg_op_a     (cfg_op_a),
        .cfg_op_b     (cfg_op_b),
        .cfg_repeat   (cfg_repeat),
        .cfg_stop     (cfg_stop),
        .rx_flit      (rx_flit),
        .rx_credit    (rx_credit),
        .rx_credit_en (rx_credit_en),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_result    (op_result),
        .tx_flit      (tx_flit),
        .tx_credit    (tx_credit),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Operator stand-in selected by the bench
    function automatic logic [63:0] alu(input int sel, input logic [63:0] a, input logic [63:0] b);
        case (sel)
            OP_ADD:  return a + b;
            OP_MUL:  return a * b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign op_result = alu(op_sel, op_a, op_b);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Job held as: active flag, queue of operand slots still wanted (0=A,1=B), result-ready flag
    bit          m_active;
    int          m_need[$];
    bit          m_have_res;
    bit          m_stop;
    bit          m_rep;
    logic [1:0]  m_mask;
    logic [3:0]  m_dest;
    logic        m_vc;
    logic [63:0] m_a, m_b, m_res;
    int          m_credit[2];
    logic        m_err;
    logic [70:0] m_tx;
    logic        m_rxen;
    logic [1:0]  m_rxcr;
    logic        m_busy, m_ready, m_done;

    task automatic model_reset();
        m_active   = 1'b0;
        m_need.delete();
        m_have_res = 1'b0;
        m_stop     = 1'b0;
        m_rep      = 1'b0;
        m_mask     = 2'b00;
        m_dest     = 4'd0;
        m_vc       = 1'b0;
        m_a        = 64'd0;
        m_b        = 64'd0;
        m_res      = 64'd0;
        m_credit[0] = BUF_DEPTH;
        m_credit[1] = BUF_DEPTH;
        m_err      = 1'b0;
        m_tx       = 71'd0;
        m_rxen     = 1'b0;
        m_rxcr     = 2'b00;
        m_busy     = 1'b0;
        m_ready    = 1'b1;
        m_done     = 1'b0;
    endtask

    task automatic arm();
        m_active   = 1'b1;
        m_have_res = 1'b0;
        m_need.delete();
        if (m_mask[0]) m_need.push_back(0);
        if (m_mask[1]) m_need.push_back(1);
    endtask

    always @(posedge CLK) begin
        bit sent;
        int c;
        if (RST) begin
            model_reset();
        end else begin
            sent   = m_tx[70];
            m_rxen = rx_flit[70];
            m_rxcr = rx_flit[70] ? {1'b1, rx_flit[64]} : 2'b00;
            if (rx_flit[70] && !(m_active && m_need.size() > 0)) m_err = 1'b1;
            if (m_active && cfg_stop) m_stop = 1'b1;
            for (int v = 0; v < 2; v++) begin
                c = m_credit[v];
                if (sent && int'(m_vc) == v) c = c - 1;
                if (tx_credit[1] && int'(tx_credit[0]) == v) c = c + 1;
                if (c > BUF_DEPTH) begin
                    c = BUF_DEPTH;
                    m_err = 1'b1;
                end
                m_credit[v] = c;
            end
            if (!m_active) begin
                if (cfg_valid) begin
                    m_dest = cfg_dest;
                    m_vc   = cfg_vc;
                    m_mask = cfg_src_mask;
                    m_rep  = cfg_repeat;
                    m_a    = cfg_src_mask[0] ? 64'd0 : cfg_op_a;
                    m_b    = cfg_src_mask[1] ? 64'd0 : cfg_op_b;
                    arm();
                end
            end else if (m_need.size() > 0) begin
                if (rx_flit[70]) begin
                    if (m_need.pop_front() == 0) m_a = rx_flit[63:0];
                    else                         m_b = rx_flit[63:0];
                end
            end else if (!m_have_res) begin
                m_res      = alu(op_sel, m_a, m_b);
                m_have_res = 1'b1;
            end else if (sent) begin
                m_have_res = 1'b0;
                if (m_rep && !m_stop) arm();
                else                  m_active = 1'b0;
            end
            if (!m_active) m_stop = 1'b0;
            m_done  = sent;
            m_tx    = (m_active && m_have_res && m_credit[m_vc] > 0) ?
                      {1'b1, 1'b1, m_dest, m_vc, m_res} : 71'd0;
            m_busy  = m_active;
            m_ready = !m_active;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("cmp_tx_flit",   tx_flit, m_tx);
            check("cmp_rx_cr_en",  71'(rx_credit_en), 71'(m_rxen));
            check("cmp_rx_credit", 71'(rx_credit), 71'(m_rxcr));
            check("cmp_op_a",      71'(op_a), 71'(m_a));
            check("cmp_op_b",      71'(op_b), 71'(m_b));
            check("cmp_busy",      71'(busy), 71'(m_busy));
            check("cmp_cfg_ready", 71'(cfg_ready), 71'(m_ready));
            check("cmp_done",      71'(done), 71'(m_done));
            check("cmp_err",       71'(err), 71'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input logic [1:0] mask, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] dest, input logic vc, input logic rep, input int sel);
        op_sel       = sel;
        cfg_src_mask = mask;
        cfg_op_a     = a;
        cfg_op_b     = b;
        cfg_dest     = dest;
        cfg_vc       = vc;
        cfg_repeat   = rep;
        cfg_valid    = 1'b1;
        tick();
        cfg_valid    = 1'b0;
    endtask

    function automatic logic [70:0] mk_flit(input logic vc, input logic [63:0] d);
        return {1'b1, 1'b1, 4'd0, vc, d};
    endfunction

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check(name, 71'(done), 71'(1));
    endtask

    task automatic wait_tx(input string name, output logic [70:0] f);
        int k = 0;
        while (tx_flit[70] !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check(name, 71'(tx_flit[70]), 71'(1));
        f = tx_flit;
    endtask

    logic [63:0] s5_in  [3];
    logic [63:0] s5_exp [3];

    initial begin
        logic [70:0] f;
        s5_in  = '{64'd1, 64'd2, 64'd4};
        s5_exp = '{64'd5, 64'd6, 64'd0};
        RST = 1'b1; cfg_valid = 1'b0; cfg_dest = 4'd0; cfg_vc = 1'b0; cfg_src_mask = 2'b00;
        cfg_op_a = 64'd0; cfg_op_b = 64'd0; cfg_repeat = 1'b0; cfg_stop = 1'b0;
        rx_flit = 71'd0; tx_credit = 2'b00;
        repeat (3) tick();
        check("rst_cfg_ready", 71'(cfg_ready), 71'(1));
        check("rst_busy",      71'(busy), 71'(0));
        check("rst_tx_flit",   tx_flit, 71'd0);
        check("rst_op_a",      71'(op_a), 71'(0));
        check("rst_err",       71'(err), 71'(0));
        check("rst_done",      71'(done), 71'(0));
        RST = 1'b0;
        tick();
        chk_en = 1'b1;

        // constants only: 10+3 to node 6 on vc0
        cfg(2'b00, 64'd10, 64'd3, 4'd6, 1'b0, 1'b0, OP_ADD);
        check("s1_tx_t1",   tx_flit, 71'd0);
        check("s1_op_a",    71'(op_a), 71'(64'd10));
        tick();
        check("s1_flit_t2", tx_flit, {1'b1, 1'b1, 4'd6, 1'b0, 64'd13});
        tick();
        check("s1_done_t3", 71'(done), 71'(1));
        check("s1_tx_off",  tx_flit, 71'd0);

        // both operands from network, multiply, vc1
        cfg(2'b11, 64'd0, 64'd0, 4'd3, 1'b1, 1'b0, OP_MUL);
        rx_flit = mk_flit(1'b0, 64'd5);
        tick();
        rx_flit = 71'd0;
        check("s2_rxcr1_en", 71'(rx_credit_en), 71'(1));
        check("s2_rxcr1",    71'(rx_credit), 71'(2'b10));
        tick();
        rx_flit = mk_flit(1'b1, 64'd8);
        tick();
        rx_flit = 71'd0;
        check("s2_rxcr2",    71'(rx_credit), 71'(2'b11));
        check("s2_op_a",     71'(op_a), 71'(64'd5));
        check("s2_op_b",     71'(op_b), 71'(64'd8));
        tick();
        check("s2_flit",     tx_flit, {1'b1, 1'b1, 4'd3, 1'b1, 64'd40});
        tick();
        check("s2_done",     71'(done), 71'(1));
        tx_credit = 2'b11;
        tick();
        tx_credit = 2'b00;

        // drain vc0 to zero credits (one already used)
        for (int i = 0; i < 7; i++) begin
            cfg(2'b00, 64'(i), 64'd1, 4'd1, 1'b0, 1'b0, OP_ADD);
            wait_done("drain_done");
        end

        // A from network, AND with 6, stalls until a vc0 credit returns
        cfg(2'b01, 64'd0, 64'd6, 4'd5, 1'b0, 1'b0, OP_AND);
        rx_flit = mk_flit(1'b0, 64'hFF);
        tick();
        rx_flit = 71'd0;
        tick();
        repeat (3) begin
            check("s3_stall_tx",   tx_flit, 71'd0);
            check("s3_stall_busy", 71'(busy), 71'(1));
            tick();
        end
        tx_credit = 2'b10;
        tick();
        tx_credit = 2'b00;
        check("s3_flit", tx_flit, {1'b1, 1'b1, 4'd5, 1'b0, 64'd6});
        tick();
        check("s3_done", 71'(done), 71'(1));

        // send and credit return on vc1 in the same cycle, then an overflow return
        check("s4_err_pre", 71'(err), 71'(0));
        cfg(2'b00, 64'h0F, 64'hF0, 4'd7, 1'b1, 1'b0, OP_OR);
        tick();
        check("s4_flit", tx_flit, {1'b1, 1'b1, 4'd7, 1'b1, 64'hFF});
        tx_credit = 2'b11;
        tick();
        tx_credit = 2'b00;
        check("s4_err_same", 71'(err), 71'(0));
        tx_credit = 2'b11;
        tick();
        tx_credit = 2'b00;
        check("s4_err_sat", 71'(err), 71'(1));

        // repeat mode: xor with 4 on three network operands, stop during the third collect
        cfg(2'b01, 64'd0, 64'd4, 4'd2, 1'b1, 1'b1, OP_XOR);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) cfg_stop = 1'b1;
            rx_flit = mk_flit(1'b1, s5_in[i]);
            tick();
            rx_flit  = 71'd0;
            cfg_stop = 1'b0;
            wait_tx("s5_tx_seen", f);
            check("s5_data", 71'(f[63:0]), 71'(s5_exp[i]));
            tick();
            check("s5_done", 71'(done), 71'(1));
            if (i < 2) check("s5_rearm_busy", 71'(busy), 71'(1));
            else       check("s5_idle_ready", 71'(cfg_ready), 71'(1));
        end

        // reset in the middle of a collect
        cfg(2'b11, 64'd0, 64'd0, 4'd9, 1'b0, 1'b0, OP_ADD);
        rx_flit = mk_flit(1'b0, 64'd7);
        tick();
        rx_flit = 71'd0;
        check("s6_op_a_cap", 71'(op_a), 71'(64'd7));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("s6_ready",    71'(cfg_ready), 71'(1));
        check("s6_busy",     71'(busy), 71'(0));
        check("s6_op_a",     71'(op_a), 71'(0));
        check("s6_err",      71'(err), 71'(0));
        check("s6_rx_en",    71'(rx_credit_en), 71'(0));

        // stray flit while idle
        rx_flit = mk_flit(1'b1, 64'd99);
        tick();
        rx_flit = 71'd0;
        check("s6_stray_en",  71'(rx_credit_en), 71'(1));
        check("s6_stray_cr",  71'(rx_credit), 71'(2'b11));
        check("s6_stray_err", 71'(err), 71'(1));
        check("s6_stray_op",  71'(op_a), 71'(0));

        // vc0 credits restored by reset: no stall
        cfg(2'b00, 64'd2, 64'd2, 4'd1, 1'b0, 1'b0, OP_MUL);
        tick();
        check("s6_flit", tx_flit, {1'b1, 1'b1, 4'd1, 1'b0, 64'd4});
        tick();
        check("s6_done", 71'(done), 71'(1));
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
